// File: rtl/io_ram_responder.sv
// io_ram_responder: byte-serial RAM plus UART TX/RX FIFOs and status in the I/O window.
// A small circular-buffer FIFO module is instantiated for TX and RX.

module io_ram_fifo #(
  parameter int LOG = 3
) (
  input  logic           clk_in,
  input  logic           rst_in_n,
  input  logic           push,
  input  logic           pop,
  input  logic [7:0]     din,
  output logic [7:0]     head,
  output logic [LOG:0]   count,
  output logic           full,
  output logic           empty
);
  localparam logic [LOG:0] DEPTH = (LOG+1)'(1 << LOG);

  logic [7:0]     buf_q [0:(1<<LOG)-1];
  logic [LOG-1:0] rd_ptr, wr_ptr;
  logic           push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  // Pop only when there is data; a push into a full FIFO is fine if a pop frees a slot.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = buf_q[rd_ptr];

  // Pointers, count and storage; storage is cleared so the head reads 0 out of reset.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < (1<<LOG); i++) buf_q[i] <= 8'h00;
    end else begin
      if (push_ok) begin
        buf_q[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end
endmodule

module io_ram_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_LOG   = 3
) (
  input  logic                clk_in,
  input  logic                rst_in_n,
  input  logic                rdy_in,
  input  logic                rw_select,
  input  logic [ADDR_WIDTH:0] addr_in,
  input  logic [7:0]          ram_store_data,
  output logic [7:0]          ram_load_data,
  output logic                io_buffer_full,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                program_end
);
  // Controller needs room for a whole 4-byte access before issuing I/O.
  localparam logic [FIFO_LOG:0] FULL_THR = (FIFO_LOG+1)'((1 << FIFO_LOG) - 4);

  logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];

  logic                is_io, wr_io0, wr_io4, rd_io0;
  logic                tx_push, tx_pop, tx_full, tx_empty, tx_overflow;
  logic                rx_push, rx_pop, rx_full, rx_empty;
  logic [FIFO_LOG:0]   tx_count, rx_count;
  logic [7:0]          rx_head, status;

  assign is_io  = (addr_in[ADDR_WIDTH:ADDR_WIDTH-1] == 2'b11);
  assign wr_io0 = rdy_in &  rw_select & is_io & (addr_in[2:0] == 3'd0);
  assign wr_io4 = rdy_in &  rw_select & is_io & (addr_in[2:0] == 3'd4);
  assign rd_io0 = rdy_in & ~rw_select & is_io & (addr_in[2:0] == 3'd0);

  assign tx_push = wr_io0;
  assign tx_pop  = rdy_in & tx_ready;
  assign rx_push = rdy_in & rx_valid;
  assign rx_pop  = rd_io0;

  assign status         = {5'b0, tx_overflow, ~rx_empty, tx_full};
  assign tx_valid       = ~tx_empty;
  assign io_buffer_full = (tx_count > FULL_THR);

  io_ram_fifo #(.LOG(FIFO_LOG)) u_tx (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .push(tx_push), .pop(tx_pop),
    .din(ram_store_data), .head(tx_data), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  io_ram_fifo #(.LOG(FIFO_LOG)) u_rx (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .push(rx_push), .pop(rx_pop),
    .din(rx_data), .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in && rw_select && !is_io) mem[addr_in[ADDR_WIDTH-1:0]] <= ram_store_data;
  end

  // Registered read data, program_end pulse and sticky TX overflow.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      ram_load_data <= 8'h00;
      program_end   <= 1'b0;
      tx_overflow   <= 1'b0;
    end else if (rdy_in) begin
      program_end <= wr_io4;
      // A full TX FIFO still accepts the byte when the UART drains one this cycle.
      if (tx_push && tx_full && !tx_ready) tx_overflow <= 1'b1;
      if (!rw_select) begin
        if (is_io) begin
          case (addr_in[2:0])
            3'd0:    ram_load_data <= rx_empty ? 8'h00 : rx_head;
            3'd4:    ram_load_data <= status;
            default: ram_load_data <= 8'h00;
          endcase
        end else begin
          ram_load_data <= mem[addr_in[ADDR_WIDTH-1:0]];
        end
      end
    end
  end
endmodule
